// File: rtl/usb_reg_pkg.sv
// ---------------------------------------------------------------------------
// usb_reg_pkg
// Shared definitions for the 8-bit parallel USB register bus responder.
//   - responder FSM state encoding
//   - default address split (total width / byte-index width)
// The REG_* register address map lives in the project defines and is not
// duplicated here.
// ---------------------------------------------------------------------------
package usb_reg_pkg;

    // Default total USB address width and the low bits that index a byte
    // within a register.
    localparam int ADDR_WIDTH_DEFAULT   = 21;
    localparam int BYTECNT_SIZE_DEFAULT = 7;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WR_STROBE  = 2'd1,
        RD_CAPTURE = 2'd2,
        HOLD       = 2'd3
    } state_e;

endpackage : usb_reg_pkg

// File: rtl/usb_reg_responder.sv
// ---------------------------------------------------------------------------
// usb_reg_responder
// Target-side responder for the CW305 8-bit parallel USB register bus.
// Every falling edge of nCS starts exactly one byte access, which is turned
// into a single-cycle reg_write or reg_read strobe towards the register bank.
// Read data is captured into usb_dout and held until the next read.
//
// Ports
//   usb_clk        bus clock, rising edge
//   reset          synchronous active-high reset
//   usb_din        byte from the data pad
//   usb_dout       byte to the data pad (held between reads)
//   usb_isout      pad output enable, 1 = FPGA drives the bus
//   usb_addr       host address {register, byte index}
//   usb_rdn        read strobe, active low
//   usb_wrn        write strobe, active low
//   usb_cen        chip select, active low
//   reg_address    register select
//   reg_bytecnt    byte index within the register
//   reg_addrvalid  high while nCS is low
//   reg_datai      read data from the register bank (combinational)
//   reg_datao      captured write data
//   reg_write      one-cycle write strobe
//   reg_read       one-cycle read strobe
//   proto_err      sticky flag: nRD and nWE both low at access start
// ---------------------------------------------------------------------------
module usb_reg_responder
    import usb_reg_pkg::*;
#(
    parameter  int pADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
    parameter  int pBYTECNT_SIZE = BYTECNT_SIZE_DEFAULT,
    localparam int pREG_WIDTH    = pADDR_WIDTH - pBYTECNT_SIZE
) (
    input  logic                     usb_clk,
    input  logic                     reset,
    input  logic [7:0]               usb_din,
    output logic [7:0]               usb_dout,
    output logic                     usb_isout,
    input  logic [pADDR_WIDTH-1:0]   usb_addr,
    input  logic                     usb_rdn,
    input  logic                     usb_wrn,
    input  logic                     usb_cen,
    output logic [pREG_WIDTH-1:0]    reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic                     reg_addrvalid,
    input  logic [7:0]               reg_datai,
    output logic [7:0]               reg_datao,
    output logic                     reg_write,
    output logic                     reg_read,
    output logic                     proto_err
);

    state_e                 state_q;
    logic                   cs_q;
    logic [7:0]             usb_dout_q;
    logic [7:0]             reg_datao_q;
    logic [pADDR_WIDTH-1:0] wr_addr_q;
    logic                   reg_write_q;
    logic                   reg_read_q;
    logic                   proto_err_q;
    logic                   start;

    // Falling edge of nCS. cs_q resets to 0 ("asserted") so that an access
    // interrupted by reset needs a fresh nCS cycle before anything happens.
    assign start = cs_q & ~usb_cen;

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cs_q        <= 1'b0;
            usb_dout_q  <= 8'h00;
            reg_datao_q <= 8'h00;
            wr_addr_q   <= '0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            cs_q        <= usb_cen;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            case (state_q)
                // HOLD also accepts a start so that a one-cycle nCS-high gap
                // is enough between back-to-back accesses.
                IDLE, HOLD: begin
                    if (start) begin
                        if (!usb_wrn && usb_rdn) begin
                            reg_datao_q <= usb_din;
                            wr_addr_q   <= usb_addr;
                            reg_write_q <= 1'b1;
                            state_q     <= WR_STROBE;
                        end else if (!usb_rdn && usb_wrn) begin
                            usb_dout_q  <= reg_datai;
                            reg_read_q  <= 1'b1;
                            state_q     <= RD_CAPTURE;
                        end else if (!usb_rdn && !usb_wrn) begin
                            proto_err_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            state_q     <= HOLD;
                        end
                    end else if (state_q == HOLD && usb_cen) begin
                        state_q <= IDLE;
                    end
                end
                WR_STROBE:  state_q <= HOLD;
                RD_CAPTURE: state_q <= HOLD;
                default:    state_q <= IDLE;
            endcase
        end
    end

    // During the write strobe the bank sees the address captured with the
    // data; otherwise it follows the live bus so read data can be looked up
    // combinationally in the start cycle.
    always_comb begin
        reg_address = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
        reg_bytecnt = usb_addr[pBYTECNT_SIZE-1:0];
        if (state_q == WR_STROBE) begin
            reg_address = wr_addr_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
            reg_bytecnt = wr_addr_q[pBYTECNT_SIZE-1:0];
        end
    end

    assign reg_addrvalid = ~usb_cen;
    assign usb_isout     = ~reset & ~usb_rdn & usb_wrn;
    assign usb_dout      = usb_dout_q;
    assign reg_datao     = reg_datao_q;
    assign reg_write     = reg_write_q;
    assign reg_read      = reg_read_q;
    assign proto_err     = proto_err_q;

endmodule : usb_reg_responder

// File: tb/tb_usb_reg_responder.sv
module tb_usb_reg_responder;

    localparam int AW = 21;
    localparam int BW = 7;
    localparam int RW = AW - BW;

    logic          usb_clk = 1'b0;
    logic          reset;
    logic [7:0]    usb_din;
    logic [7:0]    usb_dout;
    logic          usb_isout;
    logic [AW-1:0] usb_addr;
    logic          usb_rdn;
    logic          usb_wrn;
    logic          usb_cen;
    logic [RW-1:0] reg_address;
    logic [BW-1:0] reg_bytecnt;
    logic          reg_addrvalid;
    logic [7:0]    reg_datai;
    logic [7:0]    reg_datao;
    logic          reg_write;
    logic          reg_read;
    logic          proto_err;

    int tests = 0;
    int fails = 0;

    always #5 usb_clk = ~usb_clk;

    usb_reg_responder dut (
        .usb_clk       (usb_clk),
        .reset         (reset),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .usb_addr      (usb_addr),
        .usb_rdn       (usb_rdn),
        .usb_wrn       (usb_wrn),
        .usb_cen       (usb_cen),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_addrvalid (reg_addrvalid),
        .reg_datai     (reg_datai),
        .reg_datao     (reg_datao),
        .reg_write     (reg_write),
        .reg_read      (reg_read),
        .proto_err     (proto_err)
    );

    // Behavioural register bank: 64 registers x 4 bytes, preloaded on reset
    // with 0x3C at {0x07, 1}. Also logs every strobe it sees.
    logic [7:0]  bank [0:255];
    logic [7:0]  bank_idx;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [28:0] wr_log [$];   // {address, bytecnt, data}

    assign bank_idx  = {reg_address[5:0], reg_bytecnt[1:0]};
    assign reg_datai = bank[bank_idx];

    always @(posedge usb_clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
            bank[{6'h07, 2'd1}] <= 8'h3C;
        end else begin
            if (reg_write) begin
                bank[bank_idx] <= reg_datao;
                wr_cnt <= wr_cnt + 1;
                wr_log.push_back({reg_address, reg_bytecnt, reg_datao});
                $display("[TB] write reg=%h sub=%0d data=%h", reg_address, reg_bytecnt, reg_datao);
            end
            if (reg_read) begin
                rd_cnt <= rd_cnt + 1;
                $display("[TB] read  reg=%h sub=%0d data=%h", reg_address, reg_bytecnt, usb_dout);
            end
        end
    end

    // Drive one single-cycle nCS write; returns at the negedge where nCS rises.
    task automatic drive_write(input logic [13:0] r, input logic [6:0] s, input logic [7:0] d);
        @(negedge usb_clk);
        usb_addr = {r, s};
        usb_din  = d;
        usb_wrn  = 1'b0;
        usb_cen  = 1'b0;
        @(negedge usb_clk);
        usb_cen  = 1'b1;
        usb_wrn  = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; usb_cen = 1'b1; usb_rdn = 1'b1; usb_wrn = 1'b1;
        usb_din = 8'h00; usb_addr = '0;
        repeat (3) @(negedge usb_clk);
        tests++; if (usb_dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", usb_dout); end
        tests++; if (usb_isout !== 1'b0) begin fails++; $display("FAIL reset_isout: got %b want 0", usb_isout); end
        tests++; if (reg_datao !== 8'h00) begin fails++; $display("FAIL reset_datao: got %h want 00", reg_datao); end
        tests++; if ({reg_write, reg_read} !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b want 00", {reg_write, reg_read}); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto: got %b want 0", proto_err); end
        reset = 1'b0;
        repeat (2) @(negedge usb_clk);
    endtask

    task automatic test_write;
        int w0 = wr_cnt;
        @(negedge usb_clk);
        usb_addr = {14'h05, 7'd2}; usb_din = 8'hA5; usb_wrn = 1'b0; usb_cen = 1'b0;
        #1;
        tests++; if (reg_addrvalid !== 1'b1) begin fails++; $display("FAIL wr_addrvalid: got %b want 1", reg_addrvalid); end
        tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL wr_early: got %b want 0", reg_write); end
        @(negedge usb_clk);
        tests++; if (reg_write !== 1'b1) begin fails++; $display("FAIL wr_strobe: got %b want 1", reg_write); end
        tests++; if (reg_address !== 14'h05) begin fails++; $display("FAIL wr_address: got %h want 05", reg_address); end
        tests++; if (reg_bytecnt !== 7'd2) begin fails++; $display("FAIL wr_bytecnt: got %0d want 2", reg_bytecnt); end
        tests++; if (reg_datao !== 8'hA5) begin fails++; $display("FAIL wr_datao: got %h want a5", reg_datao); end
        usb_cen = 1'b1; usb_wrn = 1'b1;
        @(negedge usb_clk);
        tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL wr_single: got %b want 0", reg_write); end
        tests++; if (reg_addrvalid !== 1'b0) begin fails++; $display("FAIL wr_addrvalid_off: got %b want 0", reg_addrvalid); end
        @(negedge usb_clk);
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL wr_count: got %0d want 1", wr_cnt - w0); end
    endtask

    task automatic test_read;
        int r0 = rd_cnt;
        @(negedge usb_clk);
        usb_addr = {14'h07, 7'd1}; usb_rdn = 1'b0; usb_cen = 1'b0;
        #1;
        tests++; if (usb_isout !== 1'b1) begin fails++; $display("FAIL rd_isout_on: got %b want 1", usb_isout); end
        @(negedge usb_clk);
        tests++; if (usb_dout !== 8'h3C) begin fails++; $display("FAIL rd_dout: got %h want 3c", usb_dout); end
        tests++; if (reg_read !== 1'b1) begin fails++; $display("FAIL rd_strobe: got %b want 1", reg_read); end
        usb_cen = 1'b1;   // nRD stays low past nCS rising
        @(negedge usb_clk);
        tests++; if (reg_read !== 1'b0) begin fails++; $display("FAIL rd_single: got %b want 0", reg_read); end
        tests++; if (usb_dout !== 8'h3C) begin fails++; $display("FAIL rd_dout_hold: got %h want 3c", usb_dout); end
        tests++; if (usb_isout !== 1'b1) begin fails++; $display("FAIL rd_isout_hold: got %b want 1", usb_isout); end
        usb_rdn = 1'b1;
        #1;
        tests++; if (usb_isout !== 1'b0) begin fails++; $display("FAIL rd_isout_off: got %b want 0", usb_isout); end
        @(negedge usb_clk);
        tests++; if (rd_cnt - r0 != 1) begin fails++; $display("FAIL rd_count: got %0d want 1", rd_cnt - r0); end
    endtask

    task automatic test_long_cs;
        int w0 = wr_cnt;
        @(negedge usb_clk);
        usb_addr = {14'h05, 7'd3}; usb_din = 8'h11; usb_wrn = 1'b0; usb_cen = 1'b0;
        repeat (10) @(negedge usb_clk);
        usb_cen = 1'b1; usb_wrn = 1'b1;
        repeat (2) @(negedge usb_clk);
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL long_count: got %0d want 1", wr_cnt - w0); end
        tests++; if (wr_log[$] !== {14'h05, 7'd3, 8'h11}) begin fails++; $display("FAIL long_entry: got %h want %h", wr_log[$], {14'h05, 7'd3, 8'h11}); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL long_proto: got %b want 0", proto_err); end
    endtask

    task automatic test_illegal;
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        @(negedge usb_clk);
        usb_addr = {14'h05, 7'd0}; usb_rdn = 1'b0; usb_wrn = 1'b0; usb_cen = 1'b0;
        @(negedge usb_clk);
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL ill_proto: got %b want 1", proto_err); end
        tests++; if ({reg_write, reg_read} !== 2'b00) begin fails++; $display("FAIL ill_strobes: got %b want 00", {reg_write, reg_read}); end
        usb_cen = 1'b1; usb_rdn = 1'b1; usb_wrn = 1'b1;
        repeat (2) @(negedge usb_clk);
        tests++; if ((wr_cnt - w0) + (rd_cnt - r0) != 0) begin fails++; $display("FAIL ill_count: got %0d want 0", (wr_cnt - w0) + (rd_cnt - r0)); end
        drive_write(14'h05, 7'd0, 8'h22);
        repeat (2) @(negedge usb_clk);
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL ill_recover_count: got %0d want 1", wr_cnt - w0); end
        tests++; if (wr_log[$] !== {14'h05, 7'd0, 8'h22}) begin fails++; $display("FAIL ill_recover_entry: got %h want %h", wr_log[$], {14'h05, 7'd0, 8'h22}); end
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL ill_sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_reset_mid_write;
        int w0 = wr_cnt;
        @(negedge usb_clk);
        usb_addr = {14'h05, 7'd1}; usb_din = 8'h33; usb_wrn = 1'b0; usb_cen = 1'b0;
        reset = 1'b1;
        @(negedge usb_clk);
        tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL rst_strobe: got %b want 0", reg_write); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rst_proto: got %b want 0", proto_err); end
        tests++; if (reg_datao !== 8'h00) begin fails++; $display("FAIL rst_datao: got %h want 00", reg_datao); end
        tests++; if (usb_dout !== 8'h00) begin fails++; $display("FAIL rst_dout: got %h want 00", usb_dout); end
        @(negedge usb_clk);
        reset = 1'b0;   // nCS still low: this assertion must stay dead
        repeat (3) @(negedge usb_clk);
        usb_cen = 1'b1; usb_wrn = 1'b1;
        repeat (2) @(negedge usb_clk);
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL rst_no_write: got %0d want 0", wr_cnt - w0); end
        drive_write(14'h05, 7'd1, 8'h44);
        repeat (2) @(negedge usb_clk);
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL rst_next_count: got %0d want 1", wr_cnt - w0); end
        tests++; if (wr_log[$] !== {14'h05, 7'd1, 8'h44}) begin fails++; $display("FAIL rst_next_entry: got %h want %h", wr_log[$], {14'h05, 7'd1, 8'h44}); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        logic [28:0] want;
        int          base = wr_log.size();
        for (int i = 0; i < 8; i++) drive_write(14'h09, 7'(i % 4), bytes[i % 4]);
        repeat (2) @(negedge usb_clk);
        tests++; if (wr_log.size() - base != 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", wr_log.size() - base); end
        for (int i = 0; i < 8 && base + i < wr_log.size(); i++) begin
            want = {14'h09, 7'(i % 4), bytes[i % 4]};
            tests++;
            if (wr_log[base + i] !== want) begin fails++; $display("FAIL b2b_entry%0d: got %h want %h", i, wr_log[base + i], want); end
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge usb_clk);
            usb_addr = {14'h09, 7'(s)}; usb_rdn = 1'b0; usb_cen = 1'b0;
            @(negedge usb_clk);
            tests++;
            if (usb_dout !== bytes[s]) begin fails++; $display("FAIL b2b_read%0d: got %h want %h", s, usb_dout, bytes[s]); end
            usb_cen = 1'b1; usb_rdn = 1'b1;
        end
        repeat (2) @(negedge usb_clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_long_cs();
        test_illegal();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_usb_reg_responder
